// File: rtl/pipelined_adder.sv
// Elastic add/sub/accumulate/clear pipeline: latency STAGES cycles, 1/cycle throughput, full valid/ready backpressure.
// Define PIPELINED_ADDER_SAT_EN to clamp sub/accumulate results (sat flags a clamp); default build is modular and sat = 0.
module pipelined_adder #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum,
  output logic             sat
);

  localparam int LAST = STAGES - 1;

  typedef logic [WIDTH:0] word_t;

  logic [STAGES-1:0] vld_q;
  word_t             sum_q [STAGES];
  logic [STAGES-1:0] load;
  word_t             acc_q, acc_d;
  word_t             res_d;
  word_t             ea, eb;
  logic              accept;

  assign ea = {1'b0, a};
  assign eb = {1'b0, b};

  // A stage may load when empty or when its contents move on this cycle.
  always_comb begin
    load       = '0;
    load[LAST] = !vld_q[LAST] || out_ready;
    for (int k = STAGES - 2; k >= 0; k--) begin
      load[k] = !vld_q[k] || load[k+1];
    end
  end

  assign in_ready = load[0];
  assign accept   = in_valid && in_ready;

`ifdef PIPELINED_ADDER_SAT_EN
  logic [STAGES-1:0] sat_q;
  logic              sat_d;
  logic [WIDTH+1:0]  acc_wide;

  assign acc_wide = {1'b0, acc_q} + {2'b00, a};

  always_comb begin
    res_d = '0;
    sat_d = 1'b0;
    case (op)
      2'b00: res_d = ea + eb;
      2'b01: begin
        if (a < b) begin
          res_d = '0;
          sat_d = 1'b1;
        end else begin
          res_d = ea - eb;
        end
      end
      2'b10: begin
        if (acc_wide[WIDTH+1]) begin
          res_d = '1;
          sat_d = 1'b1;
        end else begin
          res_d = acc_wide[WIDTH:0];
        end
      end
      default: res_d = '0;
    endcase
  end
`else
  always_comb begin
    res_d = '0;
    case (op)
      2'b00:   res_d = ea + eb;
      2'b01:   res_d = ea - eb;
      2'b10:   res_d = acc_q + ea;
      default: res_d = '0;
    endcase
  end
`endif

  // The accumulator commits at acceptance so back-to-back accumulates see it.
  assign acc_d = (accept && op[1]) ? res_d : acc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      acc_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        sum_q[k] <= '0;
      end
`ifdef PIPELINED_ADDER_SAT_EN
      sat_q <= '0;
`endif
    end else begin
      acc_q <= acc_d;
      if (load[0]) begin
        vld_q[0] <= accept;
        sum_q[0] <= res_d;
`ifdef PIPELINED_ADDER_SAT_EN
        sat_q[0] <= sat_d;
`endif
      end
      for (int k = 1; k < STAGES; k++) begin
        if (load[k]) begin
          vld_q[k] <= vld_q[k-1];
          sum_q[k] <= sum_q[k-1];
`ifdef PIPELINED_ADDER_SAT_EN
          sat_q[k] <= sat_q[k-1];
`endif
        end
      end
    end
  end

  assign out_valid = vld_q[LAST];
  assign sum       = sum_q[LAST];
`ifdef PIPELINED_ADDER_SAT_EN
  assign sat       = sat_q[LAST];
`else
  assign sat       = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed-vector bench for pipelined_adder (WIDTH=8, STAGES=2) with an in-order output scoreboard.
module tb_pipelined_adder;

  localparam int WIDTH  = 8;
  localparam int STAGES = 2;
`ifdef PIPELINED_ADDER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   sum;
  logic             sat;

  pipelined_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .sat       (sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] s;
    logic       st;
    logic       lat;
    int         cyc;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] op;
    logic [8:0] s;
    logic       st;
  } vec_t;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         npop = 0;
  exp_t       sb_q[$];
  logic [8:0] drv_exp_sum = '0;
  logic       drv_exp_sat = 1'b0;
  logic       drv_chk_lat = 1'b0;
  logic       prev_stall = 1'b0;
  logic [8:0] prev_sum = '0;
  logic       prev_sat = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Output scoreboard and acceptance recorder, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && out_valid) begin
        chk("hold_sum", 32'(sum), 32'(prev_sum));
        chk("hold_sat", 32'(sat), 32'(prev_sat));
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_output: got sum %0d expected no output", sum);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("sum", 32'(sum), 32'(e.s));
          chk("sat", 32'(sat), 32'(e.st));
          if (e.lat) chk("latency", 32'(cyc - e.cyc), 32'(STAGES));
          npop++;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_sum   = sum;
      prev_sat   = sat;
      if (in_valid && in_ready)
        sb_q.push_back('{s: drv_exp_sum, st: drv_exp_sat, lat: drv_chk_lat, cyc: cyc});
    end
  end

  // Entered and left at one time unit after a rising edge.
  task automatic send(input logic [7:0] ta, input logic [7:0] tb, input logic [1:0] top,
                      input logic [8:0] es, input logic est, input logic lat, output int waited);
    a           = ta;
    b           = tb;
    op          = top;
    in_valid    = 1'b1;
    drv_exp_sum = es;
    drv_exp_sat = est;
    drv_chk_lat = lat;
    waited      = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
    end
    if (waited >= 40) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready 0 for %0d cycles expected acceptance", waited);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && !out_valid) break;
    end
    chk("drain_pending", 32'(sb_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  vec_t       vecs[16];
  int         w;
  int         acc_n;
  int         pops_before;
  logic [7:0] ra, rb;
  logic       took;

  initial begin
    #1000000;
    $display("FAIL global_timeout: got no finish expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{8'd255, 8'd255, 2'b00, 9'd510, 1'b0};
    vecs[1]  = '{8'd255, 8'd1,   2'b00, 9'd256, 1'b0};
    vecs[2]  = '{8'd0,   8'd0,   2'b00, 9'd0,   1'b0};
    vecs[3]  = '{8'd0,   8'd255, 2'b00, 9'd255, 1'b0};
    vecs[4]  = '{8'd3,   8'd5,   2'b01, SAT ? 9'd0 : 9'h1FE, SAT};
    vecs[5]  = '{8'd5,   8'd3,   2'b01, 9'd2,   1'b0};
    vecs[6]  = '{8'd0,   8'd170, 2'b11, 9'd0,   1'b0};
    vecs[7]  = '{8'd200, 8'd85,  2'b10, 9'd200, 1'b0};
    vecs[8]  = '{8'd200, 8'd0,   2'b10, 9'd400, 1'b0};
    vecs[9]  = '{8'd200, 8'd255, 2'b10, SAT ? 9'd511 : 9'd88, SAT};
    vecs[10] = '{8'd9,   8'd0,   2'b10, SAT ? 9'd511 : 9'd97, SAT};
    vecs[11] = '{8'd0,   8'd0,   2'b11, 9'd0,   1'b0};
    vecs[12] = '{8'd128, 8'd127, 2'b00, 9'd255, 1'b0};
    vecs[13] = '{8'd0,   8'd255, 2'b01, SAT ? 9'd0 : 9'd257, SAT};
    vecs[14] = '{8'd255, 8'd0,   2'b01, 9'd255, 1'b0};
    vecs[15] = '{8'd7,   8'd1,   2'b10, 9'd7,   1'b0};

    // Reset held with in_valid high.
    rst = 1'b1; in_valid = 1'b1; a = 8'd1; b = 8'd1; op = 2'b00; out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_sum", 32'(sum), 32'd0);
      chk("rst_sat", 32'(sat), 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    repeat (2) begin
      @(negedge clk);
      chk("post_rst_idle", 32'(out_valid), 32'd0);
    end
    @(posedge clk); #1;

    // Directed vectors back-to-back, latency checked per result.
    for (int i = 0; i < 16; i++)
      send(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].s, vecs[i].st, 1'b1, w);
    for (int i = 0; i < 100; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      send(ra, rb, 2'b00, {1'b0, ra} + {1'b0, rb}, 1'b0, 1'b1, w);
    end
    drain();

    // Backpressure: only STAGES adds fit while the output is stalled.
    out_ready = 1'b0;
    in_valid = 1'b1; a = 8'd1; b = 8'd1; op = 2'b00;
    drv_exp_sum = 9'd2; drv_exp_sat = 1'b0; drv_chk_lat = 1'b0;
    acc_n = 0;
    pops_before = npop;
    repeat (6) begin
      @(negedge clk);
      took = in_ready;
      if (took) acc_n++;
      @(posedge clk); #1;
      if (took) begin
        a = 8'(acc_n + 1); b = 8'(acc_n + 1);
        drv_exp_sum = 9'(2 * (acc_n + 1));
      end
    end
    chk("bp_accepted", 32'(acc_n), 32'd2);
    @(negedge clk);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(8'd3, 8'd3, 2'b00, 9'd6, 1'b0, 1'b0, w);
    chk("no_bubble_wait", 32'(w), 32'd0);
    send(8'd4, 8'd4, 2'b00, 9'd8, 1'b0, 1'b0, w);
    send(8'd5, 8'd5, 2'b00, 9'd10, 1'b0, 1'b0, w);
    drain();
    chk("bp_pop_count", 32'(npop - pops_before), 32'd5);

    // Reset mid-flight, coinciding with an offered accumulate.
    send(8'd0, 8'd0, 2'b11, 9'd0, 1'b0, 1'b1, w);
    send(8'd200, 8'd0, 2'b10, 9'd200, 1'b0, 1'b1, w);
    drain();
    out_ready = 1'b0;
    send(8'd1, 8'd2, 2'b00, 9'd3, 1'b0, 1'b0, w);
    send(8'd3, 8'd4, 2'b00, 9'd7, 1'b0, 1'b0, w);
    rst = 1'b1; out_ready = 1'b1;
    in_valid = 1'b1; a = 8'd50; b = 8'd0; op = 2'b10;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    pops_before = npop;
    send(8'd7, 8'd0, 2'b10, 9'd7, 1'b0, 1'b1, w);
    drain();
    chk("midrst_pop_count", 32'(npop - pops_before), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
